// File: rtl/sd_fifo_tail_b.sv
// sd_fifo_tail_b
// Read-side controller for the memory-based "B" FIFO. Tracks a read pointer
// against the head's committed write pointer, issues reads to a synchronous
// memory with one cycle of read latency, and hides that latency behind a
// 2-entry output buffer so that a steady stream of one word per cycle is
// possible. Optionally (commit=1) delivered words can be rewound and replayed.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   enable       arbitration grant; no new reads are issued while low
//   p_srdy       output word valid
//   p_drdy       consumer ready
//   p_data       output word (buffer head)
//   p_commit     with a pop, marks all delivered words consumed (commit=1)
//   p_abort      rewind to the last commit point (commit=1)
//   bound_low    lowest memory address owned by this FIFO
//   bound_high   highest memory address owned by this FIFO
//   wrptr        committed write pointer from the head
//   cur_rdptr    memory read address, meaningful while mem_re=1
//   com_rdptr    read pointer returned to the head for full detection
//   mem_re       memory read strobe
//   mem_rd_data  memory read data, valid the cycle after mem_re
module sd_fifo_tail_b #(
    parameter int depth  = 16,
    parameter int width  = 8,
    parameter int commit = 0,
    parameter int asz    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    input  logic             p_commit,
    input  logic             p_abort,
    input  logic [asz-1:0]   bound_low,
    input  logic [asz-1:0]   bound_high,
    input  logic [asz-1:0]   wrptr,
    output logic [asz-1:0]   cur_rdptr,
    output logic [asz-1:0]   com_rdptr,
    output logic             mem_re,
    input  logic [width-1:0] mem_rd_data
);

    // Advance a pointer by one inside [lo, hi], wrapping at hi.
    function automatic logic [asz-1:0] ptr_inc(input logic [asz-1:0] ptr,
                                               input logic [asz-1:0] lo,
                                               input logic [asz-1:0] hi);
        return (ptr == hi) ? lo : ptr + asz'(1);
    endfunction

    logic [asz-1:0]   del_rdptr;
    logic [1:0]       ocnt;
    logic             rd_pending;
    logic [width-1:0] ent0;
    logic [width-1:0] ent1;

    logic             empty;
    logic             pop;
    logic             abort_now;
    logic             capture;
    logic             capture_to_head;
    logic [2:0]       occ;
    logic [asz-1:0]   cur_rdptr_p1;
    logic [asz-1:0]   del_rdptr_p1;

    assign cur_rdptr_p1 = ptr_inc(cur_rdptr, bound_low, bound_high);
    assign del_rdptr_p1 = ptr_inc(del_rdptr, bound_low, bound_high);

    assign empty     = (cur_rdptr == wrptr);
    assign pop       = p_srdy & p_drdy;
    assign abort_now = (commit != 0) ? p_abort : 1'b0;

    // Occupancy the buffer will have once the in-flight read lands and the
    // current pop leaves; a new read is only allowed if it still fits.
    // ocnt + rd_pending never exceeds 2, and pop implies ocnt >= 1.
    assign occ    = {1'b0, ocnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign mem_re = !reset & enable & !empty & !abort_now & (occ < 3'd2);

    // A read that is in flight during an abort is dropped on the floor.
    assign capture = rd_pending & !abort_now;

    // Entry 0 is always the head; a capture lands in the first slot that is
    // free after this cycle's pop has shifted entry 1 forward.
    assign capture_to_head = (ocnt == 2'd0) || ((ocnt == 2'd1) && pop);

    assign p_srdy = (ocnt != 2'd0);
    assign p_data = ent0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_rdptr  <= bound_low;
            com_rdptr  <= bound_low;
            del_rdptr  <= bound_low;
            ocnt       <= 2'd0;
            rd_pending <= 1'b0;
            ent0       <= '0;
            ent1       <= '0;
        end else begin
            rd_pending <= mem_re;
            if (abort_now) begin
                // Rewind both read-side pointers; buffered words are discarded
                // and will be fetched again from the commit point.
                cur_rdptr <= com_rdptr;
                del_rdptr <= com_rdptr;
                ocnt      <= 2'd0;
            end else begin
                if (mem_re)
                    cur_rdptr <= cur_rdptr_p1;
                if (pop)
                    del_rdptr <= del_rdptr_p1;
                ocnt <= ocnt + {1'b0, capture} - {1'b0, pop};

                if (commit == 0) begin
                    if (pop)
                        com_rdptr <= del_rdptr_p1;
                end else begin
                    if (pop && p_commit)
                        com_rdptr <= del_rdptr_p1;
                end

                if (pop)
                    ent0 <= ent1;
                if (capture) begin
                    if (capture_to_head)
                        ent0 <= mem_rd_data;
                    else
                        ent1 <= mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_fifo_tail_b.sv
// Testbench for sd_fifo_tail_b: two instances (commit=0 and commit=1) share
// the stimulus, each with its own 1-cycle-latency memory read port.
module tb_sd_fifo_tail_b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, p_drdy, p_commit, p_abort;
    logic [3:0] bound_low, bound_high, wrptr;

    logic       srdy0, srdy1, re0, re1;
    logic [7:0] data0, data1, rd0, rd1;
    logic [3:0] cur0, cur1, com0, com1;

    logic [7:0] mem [16];

    sd_fifo_tail_b #(.depth(16), .width(8), .commit(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .p_srdy(srdy0), .p_drdy(p_drdy), .p_data(data0),
        .p_commit(p_commit), .p_abort(p_abort),
        .bound_low(bound_low), .bound_high(bound_high), .wrptr(wrptr),
        .cur_rdptr(cur0), .com_rdptr(com0), .mem_re(re0), .mem_rd_data(rd0)
    );

    sd_fifo_tail_b #(.depth(16), .width(8), .commit(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .p_srdy(srdy1), .p_drdy(p_drdy), .p_data(data1),
        .p_commit(p_commit), .p_abort(p_abort),
        .bound_low(bound_low), .bound_high(bound_high), .wrptr(wrptr),
        .cur_rdptr(cur1), .com_rdptr(com1), .mem_re(re1), .mem_rd_data(rd1)
    );

    // Synchronous memory read ports
    always @(posedge clk) begin
        if (re0) rd0 <= mem[cur0];
        if (re1) rd1 <= mem[cur1];
    end

    // Selected DUT view
    logic       sel;
    logic       m_srdy, m_re;
    logic [7:0] m_data;
    logic [3:0] m_cur, m_com;
    assign m_srdy = sel ? srdy1 : srdy0;
    assign m_re   = sel ? re1   : re0;
    assign m_data = sel ? data1 : data0;
    assign m_cur  = sel ? cur1  : cur0;
    assign m_com  = sel ? com1  : com0;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] addr_q[$];
    logic [7:0] data_q[$];
    logic [3:0] exp_a[$];
    logic [7:0] exp_d[$];

    typedef struct {
        logic [3:0] wr;
        logic       en;
        logic       drdy;
        logic       x_re;
        logic [3:0] x_cur;
        logic       x_srdy;
        logic [7:0] x_data;
        logic [3:0] x_com;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_data(input string nm);
        chk({nm, ".count"}, data_q.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++)
            if (i < data_q.size())
                chk($sformatf("%s.data[%0d]", nm, i), data_q[i], exp_d[i]);
    endtask

    task automatic cmp_addr(input string nm);
        chk({nm, ".nreads"}, addr_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++)
            if (i < addr_q.size())
                chk($sformatf("%s.addr[%0d]", nm, i), addr_q[i], exp_a[i]);
    endtask

    // Runs n cycles with the current inputs, logging read addresses and
    // popped words of the selected DUT. Starts and ends just after posedge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (m_re) addr_q.push_back(m_cur);
            if (m_srdy && p_drdy) data_q.push_back(m_data);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input logic [3:0] lo, input logic [3:0] hi);
        reset = 1'b1; bound_low = lo; bound_high = hi;
        wrptr = lo + 4'd1; enable = 1'b1; p_drdy = 1'b0;
        p_commit = 1'b0; p_abort = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset.mem_re_forced_low", m_re, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; wrptr = lo;
        @(negedge clk);
        chk("reset.p_srdy", m_srdy, 1'b0);
        chk("reset.p_data", m_data, 8'h00);
        chk("reset.cur_rdptr", m_cur, lo);
        chk("reset.com_rdptr", m_com, lo);
        chk("reset.mem_re", m_re, 1'b0);
        @(posedge clk); #1;
        addr_q.delete(); data_q.delete();
    endtask

    initial begin
        // {wr, en, drdy, x_re, x_cur, x_srdy, x_data, x_com}
        // basic stream, bounds 0..9, wrptr 0 -> 3
        tbl[0]  = '{4'd3, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 4'd0};
        tbl[1]  = '{4'd3, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 8'h00, 4'd0};
        tbl[2]  = '{4'd3, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 8'h11, 4'd0};
        tbl[3]  = '{4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 8'h22, 4'd1};
        tbl[4]  = '{4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 8'h33, 4'd2};
        tbl[5]  = '{4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'h00, 4'd3};
        // backpressure: 5 more words, wrptr 3 -> 8
        tbl[6]  = '{4'd8, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 8'h00, 4'd3};
        tbl[7]  = '{4'd8, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 8'h00, 4'd3};
        tbl[8]  = '{4'd8, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 8'h44, 4'd3};
        tbl[9]  = '{4'd8, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 8'h44, 4'd3};
        tbl[10] = '{4'd8, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 8'h44, 4'd3};
        tbl[11] = '{4'd8, 1'b1, 1'b1, 1'b1, 4'd6, 1'b1, 8'h55, 4'd4};
        tbl[12] = '{4'd8, 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 8'h66, 4'd5};
        tbl[13] = '{4'd8, 1'b1, 1'b1, 1'b0, 4'd8, 1'b1, 8'h77, 4'd6};
        tbl[14] = '{4'd8, 1'b1, 1'b1, 1'b0, 4'd8, 1'b1, 8'h88, 4'd7};
        tbl[15] = '{4'd8, 1'b1, 1'b1, 1'b0, 4'd8, 1'b0, 8'h00, 4'd8};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;

        // ---- table: stream + backpressure (commit=0) ----
        sel = 1'b0;
        do_reset(4'd0, 4'd9);
        for (int i = 0; i < 16; i++) begin
            wrptr = tbl[i].wr; enable = tbl[i].en; p_drdy = tbl[i].drdy;
            @(negedge clk);
            chk($sformatf("tbl[%0d].mem_re", i), m_re, tbl[i].x_re);
            chk($sformatf("tbl[%0d].cur_rdptr", i), m_cur, tbl[i].x_cur);
            chk($sformatf("tbl[%0d].p_srdy", i), m_srdy, tbl[i].x_srdy);
            chk($sformatf("tbl[%0d].com_rdptr", i), m_com, tbl[i].x_com);
            if (tbl[i].x_srdy)
                chk($sformatf("tbl[%0d].p_data", i), m_data, tbl[i].x_data);
            @(posedge clk); #1;
        end

        // ---- wrap: bounds 4..7, six words across the wrap ----
        sel = 1'b0;
        do_reset(4'd4, 4'd7);
        mem[4] = 8'hA1; mem[5] = 8'hA2; mem[6] = 8'hA3;
        p_drdy = 1'b1; wrptr = 4'd7;
        run(8);
        mem[7] = 8'hA4; mem[4] = 8'hA5; mem[5] = 8'hA6;
        wrptr = 4'd6;
        run(8);
        exp_a = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd4, 4'd5};
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        cmp_addr("wrap");
        cmp_data("wrap");
        chk("wrap.com_rdptr", m_com, 4'd6);

        // ---- commit/abort replay: bounds 2..9 (commit=1) ----
        sel = 1'b1;
        do_reset(4'd2, 4'd9);
        mem[2] = 8'hC1; mem[3] = 8'hC2; mem[4] = 8'hC3;
        p_drdy = 1'b1; wrptr = 4'd5;
        run(6);
        exp_d = '{8'hC1, 8'hC2, 8'hC3};
        cmp_data("commit.first");
        chk("commit.com_uncommitted", m_com, 4'd2);
        p_abort = 1'b1; p_drdy = 1'b0;
        @(posedge clk); #1;
        p_abort = 1'b0; p_drdy = 1'b1;
        chk("commit.cur_after_abort", m_cur, 4'd2);
        data_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_srdy) begin
                data_q.push_back(m_data);
                if (data_q.size() == 3) begin
                    chk("commit.com_before_commit", m_com, 4'd2);
                    p_commit = 1'b1;
                end
            end
            @(posedge clk); #1;
            p_commit = 1'b0;
        end
        cmp_data("commit.replay");
        chk("commit.com_final", m_com, 4'd5);

        // ---- abort with read in flight, then abort with full buffer ----
        sel = 1'b1;
        do_reset(4'd0, 4'd9);
        mem[0] = 8'hE0; mem[1] = 8'hE1; mem[2] = 8'hE2; mem[3] = 8'hE3; mem[4] = 8'hE4;
        p_drdy = 1'b0; wrptr = 4'd5;
        @(negedge clk);
        chk("abort.first_re", m_re, 1'b1);
        @(posedge clk); #1;
        p_abort = 1'b1;
        @(negedge clk);
        chk("abort.re_blocked", m_re, 1'b0);
        @(posedge clk); #1;
        p_abort = 1'b0;
        chk("abort.squash_srdy", m_srdy, 1'b0);
        chk("abort.rewind_cur", m_cur, 4'd0);
        run(3);
        chk("abort.buffer_full_srdy", m_srdy, 1'b1);
        chk("abort.buffer_full_data", m_data, 8'hE0);
        p_abort = 1'b1;
        @(posedge clk); #1;
        p_abort = 1'b0; p_drdy = 1'b1;
        chk("abort.flush_srdy", m_srdy, 1'b0);
        addr_q.delete(); data_q.delete();
        run(10);
        chk("abort.replay_first_addr", (addr_q.size() > 0) ? addr_q[0] : 4'hF, 4'd0);
        exp_d = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        cmp_data("abort.replay");

        // ---- enable low drains buffer, then resumes ----
        sel = 1'b0;
        do_reset(4'd0, 4'd9);
        for (int i = 0; i < 6; i++) mem[i] = 8'hF0 + 8'(i);
        p_drdy = 1'b0; wrptr = 4'd6;
        run(3);
        chk("enable.buffer_full", m_srdy, 1'b1);
        enable = 1'b0; p_drdy = 1'b1;
        addr_q.delete(); data_q.delete();
        run(4);
        exp_a = {};
        exp_d = '{8'hF0, 8'hF1};
        cmp_addr("enable.off");
        cmp_data("enable.off");
        chk("enable.off_srdy_low", m_srdy, 1'b0);
        enable = 1'b1;
        addr_q.delete(); data_q.delete();
        run(8);
        exp_a = '{4'd2, 4'd3, 4'd4, 4'd5};
        exp_d = '{8'hF2, 8'hF3, 8'hF4, 8'hF5};
        cmp_addr("enable.on");
        cmp_data("enable.on");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_fifo_tail_b.md
Name: sd_fifo_tail_b

Overview:
Read-side controller for the memory-based "B" FIFO. It is the partner of the FIFO head controller, which owns the write pointer. It compares its read pointer with the head's committed write pointer, issues reads to a synchronous memory with 1-cycle read latency, and absorbs that latency in a 2-entry output buffer. It presents a srdy/drdy producer interface and returns a read pointer to the head for full detection. Optional read-side commit/abort allows delivered words to be rewound and replayed.

Parameters:
depth, 16, number of memory entries spanned by the pointers; at most depth-1 are usable.
width, 8, data width in bits.
commit, 0, 1 enables read commit/abort behaviour.
asz, $clog2(depth), pointer width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  arbitration grant for issuing memory reads
p_srdy  output  1  output word valid
p_drdy  input  1  consumer ready
p_data  output  width  output word
p_commit  input  1  with a pop, marks all delivered words as consumed (commit=1 only)
p_abort  input  1  rewind to the last commit point (commit=1 only)
bound_low  input  asz  lowest memory address of this FIFO
bound_high  input  asz  highest memory address of this FIFO
wrptr  input  asz  committed write pointer from the head
cur_rdptr  output  asz  memory read address, valid when mem_re=1
com_rdptr  output  asz  read pointer returned to the head
mem_re  output  1  memory read strobe
mem_rd_data  input  width  memory data, valid the cycle after mem_re

Behaviour:
- Reset: synchronous, active-high; clock clk.
- Values during reset: cur_rdptr, com_rdptr and the internal delivered pointer del_rdptr = bound_low; buffer count ocnt = 0; rd_pending = 0; buffer entries = 0. Therefore p_srdy = 0 and p_data = 0. mem_re is forced to 0 while reset is high.
- Pointer increment: ptr_p1 = (ptr == bound_high) ? bound_low : ptr + 1. The same rule applies to every pointer.
- Empty: empty = (cur_rdptr == wrptr).
- Pop: pop = p_srdy & p_drdy.
- Read issue: mem_re = enable & !empty & !abort_now & (ocnt + rd_pending - pop < 2).
  - On mem_re: cur_rdptr <= cur_rdptr_p1.
  - rd_pending <= mem_re.
- Capture: when rd_pending = 1 and the read is not squashed, mem_rd_data is written to the buffer tail.
  - Buffer is FIFO-ordered with 2 entries.
  - ocnt updates as +capture - pop; simultaneous capture and pop is allowed.
- Output: p_srdy = (ocnt != 0); p_data = buffer head.
- Latency: if wrptr first differs from cur_rdptr in cycle T with enable = 1, mem_re is asserted in T and p_srdy is asserted in T+2. Sustained throughput is 1 word/cycle while p_drdy = 1.
- Buffer never overflows; this is guaranteed by the issue condition.
- Delivered pointer: each pop advances del_rdptr by one with wrap.
- commit = 0:
  - com_rdptr follows del_rdptr after every pop.
  - p_commit and p_abort are ignored.
- commit = 1, commit:
  - pop & p_commit & !p_abort: com_rdptr <= del_rdptr_p1.
  - Otherwise com_rdptr holds.
- commit = 1, abort (abort_now = commit & p_abort):
  - cur_rdptr <= com_rdptr; del_rdptr <= com_rdptr.
  - ocnt <= 0.
  - Any read in flight this cycle is squashed; its data is not captured.
  - mem_re = 0 in the abort cycle.
  - Abort takes priority over a simultaneous pop or commit. That word is not consumed and will be redelivered.
- enable low: no new reads are issued. An in-flight read still completes. Buffered words still drain.
- wrptr moving backward (head abort): a read that was already issued is not retracted. The head only moves wrptr after commit, so this does not occur.
- Reset mid-stream: in the cycle after reset all state returns to its reset values. Buffered and in-flight data are discarded.

Test Plan:
1. commit=0, bounds 0..9, wrptr goes 0→3 at cycle T, p_drdy=1 -> mem_re in T, T+1, T+2 with cur_rdptr 0, 1, 2; words D0, D1, D2 appear with p_srdy=1 in T+2..T+4; com_rdptr reads 1, 2, 3 after each pop; p_srdy=0 in T+5.
2. Backpressure: 5 words available, p_drdy=0 -> exactly 2 mem_re pulses, ocnt=2, no further reads; then p_drdy=1 -> remaining 3 words fetched; all 5 words delivered in order, 1/cycle, with no bubble after the first.
3. Wrap: bounds 4..7, head writes 6 words across the wrap -> read addresses 4, 5, 6, 7, 4, 5; data order preserved; com_rdptr ends at 6.
4. commit=1: pop 3 words with p_commit=0, then p_abort=1 -> com_rdptr stays at bound_low; the same 3 words are redelivered; pop the 3rd with p_commit=1 -> com_rdptr = bound_low+3.
5. Abort with a read in flight and ocnt=2 -> next cycle p_srdy=0; the squashed data never appears; the replay starts at com_rdptr.
6. enable=0 with ocnt=2 and 4 more words available -> mem_re stays 0; the 2 buffered words drain; p_srdy then drops to 0; reasserting enable resumes at the next address.
